// File: rtl/tl_pkg.sv
// Shared types and constants for the traffic light controller.
// Lamp vectors are {red, yellow, green}.
package tl_pkg;

   typedef enum logic [2:0] {
      ALL_RED_A = 3'd0,
      NS_GREEN  = 3'd1,
      NS_YELLOW = 3'd2,
      ALL_RED_B = 3'd3,
      EW_GREEN  = 3'd4,
      EW_YELLOW = 3'd5,
      WALK      = 3'd6,
      FLASH     = 3'd7
   } tl_state_e;

   localparam logic [2:0] LAMP_RED = 3'b100;
   localparam logic [2:0] LAMP_YEL = 3'b010;
   localparam logic [2:0] LAMP_GRN = 3'b001;
   localparam logic [2:0] LAMP_OFF = 3'b000;

   localparam logic MODE_LONG  = 1'b0;
   localparam logic MODE_SHORT = 1'b1;

   // Green and walk phases use the long back-counter period.
   function automatic logic mode_of(input tl_state_e s);
      logic m;
      case (s)
         NS_GREEN, EW_GREEN, WALK: m = MODE_LONG;
         default:                  m = MODE_SHORT;
      endcase
      return m;
   endfunction

endpackage

// File: rtl/rise_detect.sv
// Rising-edge detector: rise is high for the one cycle in which d is high
// and its registered copy is still low.
module rise_detect (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic rise
);

   logic d_r;

   // History register for d.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         d_r <= 1'b0;
      end else begin
         d_r <= d;
      end
   end

   assign rise = d & ~d_r;

endmodule

// File: rtl/traffic_light_controller.sv
// Two-direction traffic light controller with pedestrian phase and
// flashing-yellow night operation, stepped by back-counter timeout edges.
module traffic_light_controller
   import tl_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       pulse,
   input  logic       timeout,
   input  logic       night,
   input  logic       ped_req,
   output logic       mode,
   output logic [2:0] ns_light,
   output logic [2:0] ew_light,
   output logic       walk
);

   tl_state_e  state_r;
   tl_state_e  next_state_s;
   logic       edge_s;
   logic       ped_pending_r;
   logic       ped_next_s;
   logic       flash_on_r;
   logic       flash_next_s;
   logic [2:0] ns_next_s;
   logic [2:0] ew_next_s;
   logic       mode_next_s;
   logic       walk_next_s;

   rise_detect u_timeout_rise (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (timeout),
      .rise  (edge_s)
   );

   // Next-state selection; only a fresh timeout edge moves the FSM.
   always_comb begin
      next_state_s = state_r;
      if (edge_s) begin
         case (state_r)
            ALL_RED_A: begin
               if (night) begin
                  next_state_s = FLASH;
               end else if (ped_pending_r) begin
                  next_state_s = WALK;
               end else begin
                  next_state_s = NS_GREEN;
               end
            end
            NS_GREEN:  next_state_s = NS_YELLOW;
            NS_YELLOW: next_state_s = ALL_RED_B;
            ALL_RED_B: next_state_s = night ? FLASH : EW_GREEN;
            EW_GREEN:  next_state_s = EW_YELLOW;
            EW_YELLOW: next_state_s = ALL_RED_A;
            WALK:      next_state_s = NS_GREEN;
            FLASH:     next_state_s = night ? FLASH : ALL_RED_A;
            default:   next_state_s = ALL_RED_A;
         endcase
      end else begin
         next_state_s = state_r;
      end
   end

   // Pedestrian latch and flash phase; WALK entry wins over a same-cycle request.
   always_comb begin
      ped_next_s   = ped_pending_r;
      flash_next_s = 1'b0;
      if ((next_state_s == WALK) && (state_r != WALK)) begin
         ped_next_s = 1'b0;
      end else if (ped_req && (state_r != WALK)) begin
         ped_next_s = 1'b1;
      end else begin
         ped_next_s = ped_pending_r;
      end
      if (next_state_s != FLASH) begin
         flash_next_s = 1'b0;
      end else if (state_r != FLASH) begin
         flash_next_s = 1'b1;
      end else if (pulse) begin
         flash_next_s = ~flash_on_r;
      end else begin
         flash_next_s = flash_on_r;
      end
   end

   // Output decode from the upcoming state so outputs register with it.
   always_comb begin
      ns_next_s   = LAMP_RED;
      ew_next_s   = LAMP_RED;
      mode_next_s = mode_of(next_state_s);
      walk_next_s = 1'b0;
      case (next_state_s)
         NS_GREEN:  ns_next_s = LAMP_GRN;
         NS_YELLOW: ns_next_s = LAMP_YEL;
         EW_GREEN:  ew_next_s = LAMP_GRN;
         EW_YELLOW: ew_next_s = LAMP_YEL;
         WALK:      walk_next_s = 1'b1;
         FLASH: begin
            ns_next_s = flash_next_s ? LAMP_YEL : LAMP_OFF;
            ew_next_s = flash_next_s ? LAMP_YEL : LAMP_OFF;
         end
         default: begin
            ns_next_s = LAMP_RED;
            ew_next_s = LAMP_RED;
         end
      endcase
   end

   // State, latches and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r       <= ALL_RED_A;
         ped_pending_r <= 1'b0;
         flash_on_r    <= 1'b0;
         ns_light      <= LAMP_RED;
         ew_light      <= LAMP_RED;
         mode          <= MODE_SHORT;
         walk          <= 1'b0;
      end else begin
         state_r       <= next_state_s;
         ped_pending_r <= ped_next_s;
         flash_on_r    <= flash_next_s;
         ns_light      <= ns_next_s;
         ew_light      <= ew_next_s;
         mode          <= mode_next_s;
         walk          <= walk_next_s;
      end
   end

endmodule

// File: doc/traffic_light_controller.md
TRAFFIC_LIGHT_CONTROLLER -- requirements
Module: traffic_light_controller

Interface
REQ-001 The block SHALL have no parameters; all phase encodings are fixed constants from tl_pkg.
REQ-002 clk  input  1  single system clock; all state SHALL change on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 pulse  input  1  one-clk-wide 1 Hz tick, shared with the second back-counter.
REQ-005 timeout  input  1  phase-expired level from the back-counter; held across a whole pulse period.
REQ-006 night  input  1  level request for flashing-yellow night operation.
REQ-007 ped_req  input  1  pedestrian button; any single-cycle high SHALL be latched.
REQ-008 mode  output  1  phase-length select to the back-counter: 0 = long (10 s), 1 = short (5 s).
REQ-009 ns_light  output  3  north-south lamps {red, yellow, green}, one-hot or all-zero.
REQ-010 ew_light  output  3  east-west lamps {red, yellow, green}, one-hot or all-zero.
REQ-011 walk  output  1  pedestrian walk lamp.

Function
REQ-012 The block SHALL advance only on a timeout rising edge (timeout=1 this cycle, registered copy=0); a held-high timeout SHALL NOT cause further advances.
REQ-013 The block SHALL implement states ALL_RED_A, NS_GREEN, NS_YELLOW, ALL_RED_B, EW_GREEN, EW_YELLOW, WALK, FLASH.
REQ-014 Cycle on each edge SHALL be ALL_RED_A->NS_GREEN->NS_YELLOW->ALL_RED_B->EW_GREEN->EW_YELLOW->ALL_RED_A.
REQ-015 At an edge in ALL_RED_A, priority SHALL be: night=1 -> FLASH; else ped_pending=1 -> WALK; else -> NS_GREEN.
REQ-016 At an edge in ALL_RED_B, night=1 SHALL go to FLASH; otherwise the next state SHALL be EW_GREEN.
REQ-017 At an edge in WALK, the next state SHALL be NS_GREEN.
REQ-018 At an edge in FLASH, night=0 SHALL go to ALL_RED_A; night=1 SHALL stay in FLASH.
REQ-019 night SHALL be ignored in the green and yellow states; a green is never cut short.
REQ-020 mode SHALL be 0 in NS_GREEN, EW_GREEN and WALK, and 1 in all other states.
REQ-021 mode, lamps and walk SHALL be registered and SHALL update in the same cycle as the state register, one clk after the detected edge.
REQ-022 Each direction SHALL show red=100, yellow=010 or green=001; in ALL_RED_*, WALK and FLASH the non-flashing value SHALL be 100.
REQ-023 walk SHALL be 1 only in WALK.
REQ-024 In FLASH, both lamps SHALL toggle between 010 and 000 on every pulse, starting at 010 on entry.
REQ-025 The ped_pending register SHALL be set by ped_req in any state except WALK, and cleared on entry to WALK.
REQ-026 A ped_req in the same cycle as WALK entry SHALL be dropped.
REQ-027 ped_pending SHALL persist through FLASH.
REQ-028 Both directions SHALL never show a non-red lamp simultaneously outside FLASH.

Reset
REQ-029 On rst_n=0, the block SHALL set state=ALL_RED_A, ns_light=ew_light=100, mode=1, walk=0, ped_pending=0 and the timeout history register to 0.
REQ-030 Reset mid-phase SHALL return the block to ALL_RED_A immediately, independent of clk.

Structure
REQ-031 Package tl_pkg SHALL hold the state enum, lamp constants (LAMP_RED/YEL/GRN/OFF) and MODE_LONG/MODE_SHORT.
REQ-032 The design SHALL include one sub-module, rise_detect (registered edge detector), instanced for timeout.

Verification
REQ-033 The bench SHALL release reset with timeout held at 1, then check that exactly one advance occurs (ALL_RED_A->NS_GREEN, ns=001, mode=0) until timeout falls and rises again.
REQ-034 The bench SHALL apply six timeout edges with night=0 and ped_req=0, then check the full cycle ends in ALL_RED_A with mode sequence 0,1,1,0,1,1.
REQ-035 The bench SHALL pulse ped_req for one clk during EW_GREEN, then check that the next ALL_RED_A edge enters WALK (walk=1, mode=0, both 100) and that the following edge enters NS_GREEN.
REQ-036 The bench SHALL raise night during NS_GREEN, then check that NS_YELLOW and ALL_RED_B still occur and that FLASH follows with lamps toggling 010/000 per pulse.
REQ-037 The bench SHALL drop night in FLASH with ped_pending=1, then check the sequence FLASH->ALL_RED_A->WALK.
REQ-038 The bench SHALL assert rst_n=0 during WALK, then check the outputs return to 100/100, mode=1, walk=0 with no clk edge, and that ped_pending is cleared.
